// File: rtl/reg_bank.sv
// Working-register bank: two read ports, an ALU writeback port and a
// split-transaction memory-load port that tracks one outstanding load.
module reg_bank #(
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_req,
  input  logic [IDX_W-1:0] load_idx,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data_write,
  input  logic             wb_en,
  input  logic [IDX_W-1:0] wb_idx,
  input  logic [WIDTH-1:0] result,
  input  logic [IDX_W-1:0] rd_idx_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             load_ready,
  output logic             hazard,
  output logic             err_overlap
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] pend_q, pend_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];

  logic             ld_we;
  logic [IDX_W-1:0] ld_idx;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    err_d   = err_q;
    ld_we   = 1'b0;
    ld_idx  = load_idx;
    unique case (state_q)
      IDLE: begin
        if (load_req && data_valid) begin
          ld_we  = 1'b1;
          ld_idx = load_idx;
        end else if (load_req) begin
          pend_d  = load_idx;
          state_d = PEND;
        end
      end
      PEND: begin
        if (load_req)
          err_d = 1'b1;
        if (data_valid) begin
          ld_we   = 1'b1;
          ld_idx  = pend_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load data has priority over a writeback to the same register.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (ld_we && ld_idx == IDX_W'(i))
        regs_d[i] = data_write;
      else if (wb_en && wb_idx == IDX_W'(i))
        regs_d[i] = result;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      err_q   <= 1'b0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
      regs_q  <= regs_d;
    end
  end

  // Indices past NUM_REGS match nothing and read as zero.
  function automatic logic [WIDTH-1:0] rd(input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == IDX_W'(i))
        v = regs_q[i];
    return v;
  endfunction

  assign rd_data_a   = rd(rd_idx_a);
  assign rd_data_b   = rd(rd_idx_b);
  assign load_ready  = (state_q == IDLE);
  assign hazard      = (state_q == PEND) &&
                       ((rd_idx_a == pend_q) || (rd_idx_b == pend_q));
  assign err_overlap = err_q;

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: vector table of per-cycle stimulus and
// expected post-edge outputs, plus a short hand sequence.
module tb_reg_bank;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_req;
  logic [IW-1:0] load_idx;
  logic          data_valid;
  logic [W-1:0]  data_write;
  logic          wb_en;
  logic [IW-1:0] wb_idx;
  logic [W-1:0]  result;
  logic [IW-1:0] rd_idx_a;
  logic [IW-1:0] rd_idx_b;
  logic [W-1:0]  rd_data_a;
  logic [W-1:0]  rd_data_b;
  logic          load_ready;
  logic          hazard;
  logic          err_overlap;

  always #5 clk = ~clk;

  reg_bank #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_req    (load_req),
    .load_idx    (load_idx),
    .data_valid  (data_valid),
    .data_write  (data_write),
    .wb_en       (wb_en),
    .wb_idx      (wb_idx),
    .result      (result),
    .rd_idx_a    (rd_idx_a),
    .rd_idx_b    (rd_idx_b),
    .rd_data_a   (rd_data_a),
    .rd_data_b   (rd_data_b),
    .load_ready  (load_ready),
    .hazard      (hazard),
    .err_overlap (err_overlap)
  );

  typedef struct {
    logic          rst;
    logic          lreq;
    logic [IW-1:0] lidx;
    logic          dv;
    logic [W-1:0]  dw;
    logic          wb;
    logic [IW-1:0] widx;
    logic [W-1:0]  res;
    logic [IW-1:0] ra;
    logic [IW-1:0] rb;
    logic [W-1:0]  ea;
    logic [W-1:0]  eb;
    logic          erdy;
    logic          ehaz;
    logic          eerr;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic add(
    input logic rst, input logic lreq, input logic [IW-1:0] lidx,
    input logic dv, input logic [W-1:0] dw,
    input logic wb, input logic [IW-1:0] widx, input logic [W-1:0] res,
    input logic [IW-1:0] ra, input logic [IW-1:0] rb,
    input logic [W-1:0] ea, input logic [W-1:0] eb,
    input logic erdy, input logic ehaz, input logic eerr);
    vec_t v;
    v = '{rst, lreq, lidx, dv, dw, wb, widx, res, ra, rb,
          ea, eb, erdy, ehaz, eerr};
    vecs.push_back(v);
  endtask

  task automatic check(input string name,
                       input logic [W-1:0] ea, input logic [W-1:0] eb,
                       input logic erdy, input logic ehaz,
                       input logic eerr);
    n_cmp++;
    if (rd_data_a !== ea || rd_data_b !== eb || load_ready !== erdy ||
        hazard !== ehaz || err_overlap !== eerr) begin
      n_bad++;
      $display("FAIL %s: got a=%h b=%h rdy=%b haz=%b err=%b, want a=%h b=%h rdy=%b haz=%b err=%b",
               name, rd_data_a, rd_data_b, load_ready, hazard, err_overlap,
               ea, eb, erdy, ehaz, eerr);
    end
  endtask

  initial begin
    reset = 1'b0; load_req = 1'b0; load_idx = '0;
    data_valid = 1'b0; data_write = '0;
    wb_en = 1'b0; wb_idx = '0; result = '0;
    rd_idx_a = '0; rd_idx_b = '0;

    // rst lreq lidx dv dw wb widx res ra rb ea eb rdy haz err
    add(0,0,0, 1,8'hFF, 1,0,8'h77, 0,1, 8'h00,8'h00, 1,0,0); // reset 1
    add(0,0,0, 1,8'hFF, 1,1,8'h77, 2,3, 8'h00,8'h00, 1,0,0); // reset 2
    add(1,1,2, 1,8'hA5, 0,0,8'h00, 2,0, 8'hA5,8'h00, 1,0,0); // zero-wait
    add(1,1,1, 0,8'h00, 0,0,8'h00, 2,1, 8'hA5,8'h00, 0,1,0); // split req
    add(1,0,0, 0,8'h00, 0,0,8'h00, 0,1, 8'h00,8'h00, 0,1,0);
    add(1,0,0, 0,8'h00, 0,0,8'h00, 0,1, 8'h00,8'h00, 0,1,0);
    add(1,0,0, 0,8'h00, 0,0,8'h00, 3,2, 8'h00,8'hA5, 0,0,0); // no match
    add(1,0,0, 1,8'h3C, 0,0,8'h00, 1,1, 8'h3C,8'h3C, 1,0,0); // complete
    add(1,0,0, 1,8'hEE, 0,0,8'h00, 1,2, 8'h3C,8'hA5, 1,0,0); // stray dv
    add(1,1,3, 1,8'h11, 1,3,8'h22, 3,0, 8'h11,8'h00, 1,0,0); // same idx
    add(1,1,3, 1,8'h11, 1,0,8'h22, 3,0, 8'h11,8'h22, 1,0,0); // diff idx
    add(1,1,0, 0,8'h00, 0,0,8'h00, 0,3, 8'h22,8'h11, 0,1,0); // pend 0
    add(1,0,0, 0,8'h00, 1,0,8'h55, 0,3, 8'h55,8'h11, 0,1,0); // WAW wb
    add(1,0,0, 1,8'h66, 0,0,8'h00, 0,3, 8'h66,8'h11, 1,0,0); // load wins
    add(1,1,1, 0,8'h00, 0,0,8'h00, 2,3, 8'hA5,8'h11, 0,0,0); // pend 1
    add(1,1,2, 0,8'h00, 0,0,8'h00, 2,1, 8'hA5,8'h3C, 0,1,1); // overlap
    add(0,0,0, 0,8'h00, 0,0,8'h00, 2,1, 8'h00,8'h00, 1,0,0); // mid reset
    add(1,0,0, 1,8'h99, 0,0,8'h00, 1,0, 8'h00,8'h00, 1,0,0); // dv dropped
    add(1,1,3, 0,8'h00, 0,0,8'h00, 3,0, 8'h00,8'h00, 0,1,0); // pend 3
    add(1,1,1, 1,8'h4D, 0,0,8'h00, 3,1, 8'h4D,8'h00, 1,0,1); // req+dv

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      load_req   = vecs[i].lreq;
      load_idx   = vecs[i].lidx;
      data_valid = vecs[i].dv;
      data_write = vecs[i].dw;
      wb_en      = vecs[i].wb;
      wb_idx     = vecs[i].widx;
      result     = vecs[i].res;
      rd_idx_a   = vecs[i].ra;
      rd_idx_b   = vecs[i].rb;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
            vecs[i].erdy, vecs[i].ehaz, vecs[i].eerr);
    end

    // Reads are not bypassed: a pending writeback is invisible pre-edge.
    reset = 1'b1; load_req = 1'b0; data_valid = 1'b0;
    wb_en = 1'b1; wb_idx = 2'd2; result = 8'hC3;
    rd_idx_a = 2'd2; rd_idx_b = 2'd3;
    #1;
    check("no_bypass", 8'h00, 8'h4D, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    check("wb_visible", 8'hC3, 8'h4D, 1'b1, 1'b0, 1'b1);

    // Hazard tracks the read indices combinationally while pending.
    load_req = 1'b1; load_idx = 2'd2;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rd_idx_a = 2'd0; rd_idx_b = 2'd1;
    #1;
    check("haz_off", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    rd_idx_b = 2'd2;
    #1;
    check("haz_on", 8'h00, 8'hC3, 1'b0, 1'b1, 1'b1);
    data_valid = 1'b1; data_write = 8'h5A;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    check("haz_drop", 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
